// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with WB bypass, load-use hazard detection and bubble counting.
// Build option: define ID_WB_BYPASS_EN for same-cycle WB forwarding, otherwise WB conflicts stall.
module id_ex_stage_reg #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned REG_ADDR_WIDTH = 5
) (
   input  logic                      i_clk,
   input  logic                      i_reset,
   input  logic                      i_valid,
   input  logic                      i_stall,
   input  logic                      i_flush,
   input  logic [REG_ADDR_WIDTH-1:0] i_rs,
   input  logic [REG_ADDR_WIDTH-1:0] i_rt,
   input  logic [REG_ADDR_WIDTH-1:0] i_rd,
   input  logic [DATA_WIDTH-1:0]     i_read_data_1,
   input  logic [DATA_WIDTH-1:0]     i_read_data_2,
   input  logic [DATA_WIDTH-1:0]     i_imm,
   input  logic                      i_reg_write,
   input  logic                      i_mem_read,
   input  logic                      i_mem_write,
   input  logic                      i_mem_to_reg,
   input  logic                      i_alu_src,
   input  logic                      i_reg_dst,
   input  logic [3:0]                i_alu_op,
   input  logic                      i_wb_write_enable,
   input  logic [REG_ADDR_WIDTH-1:0] i_wb_write_register,
   input  logic [DATA_WIDTH-1:0]     i_wb_write_data,
   output logic                      o_valid,
   output logic [REG_ADDR_WIDTH-1:0] o_rs,
   output logic [REG_ADDR_WIDTH-1:0] o_rt,
   output logic [REG_ADDR_WIDTH-1:0] o_rd,
   output logic [DATA_WIDTH-1:0]     o_data_1,
   output logic [DATA_WIDTH-1:0]     o_data_2,
   output logic [DATA_WIDTH-1:0]     o_imm,
   output logic                      o_reg_write,
   output logic                      o_mem_read,
   output logic                      o_mem_write,
   output logic                      o_mem_to_reg,
   output logic                      o_alu_src,
   output logic                      o_reg_dst,
   output logic [3:0]                o_alu_op,
   output logic                      o_hazard_stall,
   output logic [15:0]               o_bubble_count
);

   logic                  bypass_1;
   logic                  bypass_2;
   logic                  load_use;
   logic                  load_bubble;
   logic [DATA_WIDTH-1:0] data_1;
   logic [DATA_WIDTH-1:0] data_2;

   always_comb begin
      bypass_1 = i_wb_write_enable && (i_wb_write_register != '0) &&
                 (i_wb_write_register == i_rs);
      bypass_2 = i_wb_write_enable && (i_wb_write_register != '0) &&
                 (i_wb_write_register == i_rt);
      load_use = o_valid && o_mem_read && i_valid && (o_rt != '0) &&
                 ((o_rt == i_rs) || (o_rt == i_rt));
`ifdef ID_WB_BYPASS_EN
      o_hazard_stall = load_use;
      data_1         = bypass_1 ? i_wb_write_data : i_read_data_1;
      data_2         = bypass_2 ? i_wb_write_data : i_read_data_2;
`else
      // Without forwarding, wait one cycle for the bank write to retire.
      o_hazard_stall = load_use || (i_valid && (bypass_1 || bypass_2));
      data_1         = i_read_data_1;
      data_2         = i_read_data_2;
`endif
      load_bubble = i_flush || (!i_stall && o_hazard_stall);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_valid        <= 1'b0;
         o_rs           <= '0;
         o_rt           <= '0;
         o_rd           <= '0;
         o_data_1       <= '0;
         o_data_2       <= '0;
         o_imm          <= '0;
         o_reg_write    <= 1'b0;
         o_mem_read     <= 1'b0;
         o_mem_write    <= 1'b0;
         o_mem_to_reg   <= 1'b0;
         o_alu_src      <= 1'b0;
         o_reg_dst      <= 1'b0;
         o_alu_op       <= '0;
         o_bubble_count <= '0;
      end else if (load_bubble) begin
         o_valid      <= 1'b0;
         o_rs         <= '0;
         o_rt         <= '0;
         o_rd         <= '0;
         o_data_1     <= '0;
         o_data_2     <= '0;
         o_imm        <= '0;
         o_reg_write  <= 1'b0;
         o_mem_read   <= 1'b0;
         o_mem_write  <= 1'b0;
         o_mem_to_reg <= 1'b0;
         o_alu_src    <= 1'b0;
         o_reg_dst    <= 1'b0;
         o_alu_op     <= '0;
         if ((o_valid || i_valid) && (o_bubble_count != 16'hFFFF)) begin
            o_bubble_count <= o_bubble_count + 16'd1;
         end
      end else if (!i_stall) begin
         o_valid      <= i_valid;
         o_rs         <= i_rs;
         o_rt         <= i_rt;
         o_rd         <= i_rd;
         o_data_1     <= data_1;
         o_data_2     <= data_2;
         o_imm        <= i_imm;
         // An empty slot must never carry live control.
         o_reg_write  <= i_reg_write  && i_valid;
         o_mem_read   <= i_mem_read   && i_valid;
         o_mem_write  <= i_mem_write  && i_valid;
         o_mem_to_reg <= i_mem_to_reg && i_valid;
         o_alu_src    <= i_alu_src    && i_valid;
         o_reg_dst    <= i_reg_dst    && i_valid;
         o_alu_op     <= i_valid ? i_alu_op : 4'd0;
      end
   end

endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

Pipeline register between instruction decode and execute. It captures the two register-bank read values, the sign-extended immediate, the register indices and the decoded control fields. It bypasses a same-cycle writeback into the captured operands, detects load-use hazards and inserts bubbles. It also holds its contents on a downstream stall, and it counts inserted bubbles for performance monitoring.

## Interface
- DATA_WIDTH, 32, operand/immediate width
- REG_ADDR_WIDTH, 5, register index width
- i_clk  in  1  clock, rising edge
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  ID holds a real instruction
- i_stall  in  1  downstream hold: freeze all state
- i_flush  in  1  branch/jump squash: load a bubble
- i_rs, i_rt, i_rd  in  REG_ADDR_WIDTH  decoded register indices
- i_read_data_1, i_read_data_2  in  DATA_WIDTH  register-bank read values for rs/rt
- i_imm  in  DATA_WIDTH  sign-extended immediate
- i_reg_write, i_mem_read, i_mem_write, i_mem_to_reg, i_alu_src, i_reg_dst  in  1 each  control fields
- i_alu_op  in  4  ALU operation
- i_wb_write_enable  in  1  writeback write strobe (same signal driving the bank)
- i_wb_write_register  in  REG_ADDR_WIDTH  writeback destination
- i_wb_write_data  in  DATA_WIDTH  writeback data
- o_valid  out  1  EX holds a real instruction
- o_rs, o_rt, o_rd  out  REG_ADDR_WIDTH  registered indices
- o_data_1, o_data_2, o_imm  out  DATA_WIDTH  registered operands/immediate
- o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_alu_src, o_reg_dst  out  1 each  registered control
- o_alu_op  out  4  registered ALU op
- o_hazard_stall  out  1  combinational: IF and IF/ID must hold this cycle
- o_bubble_count  out  16  saturating count of inserted bubbles

## Operation
- Reset: all outputs 0. This includes o_valid, the control fields, the data outputs, the indices and o_bubble_count.
- Load-use hazard (combinational), asserted when all of the following hold:
  - o_valid & o_mem_read & i_valid
  - o_rt != 0
  - o_rt == i_rs, or o_rt == i_rt
- Per-edge priority, highest first:
  - reset
  - i_flush: load a bubble
  - i_stall: hold everything
  - o_hazard_stall: load a bubble
  - otherwise: load the ID inputs, with o_valid <= i_valid
- Bubble: o_valid=0. All control outputs are forced to 0, so reg_write and mem_write cannot fire. Data and index outputs are don't-care and are loaded as 0.
- A load with i_valid=0 also forces the control outputs to 0.
- Operand capture:
  - o_data_1 takes i_wb_write_data when the bypass condition holds for rs; otherwise it takes i_read_data_1.
  - o_data_2 follows the same rule with rt.
  - Bypass condition (see Configuration): i_wb_write_enable & i_wb_write_register != 0 & i_wb_write_register equals the index.
- o_bubble_count increments by 1 on each edge that loads a bubble because of i_flush or o_hazard_stall while o_valid or i_valid is 1. It saturates at 0xFFFF and does not change during i_stall.

## Timing
- Latency 1 cycle: ID inputs sampled at edge N appear on the outputs after edge N.
- o_hazard_stall is a function of registered state and same-cycle ID indices only, with no dependence on the data inputs. It is asserted for exactly one cycle per load-use pair, because the bubble clears o_mem_read on the next edge.
- i_flush and o_hazard_stall in the same cycle: flush wins, one bubble, counter +1.
- i_stall and o_hazard_stall in the same cycle: hold. o_hazard_stall stays asserted and is re-evaluated after the stall releases.
- i_flush and i_stall in the same cycle: flush wins.
- A write to register 0 is never bypassed; the captured value is i_read_data_x, which the bank holds at 0.

## Configuration
- ID_WB_BYPASS_EN defined: the same-cycle writeback bypass is active as described above.
- ID_WB_BYPASS_EN undefined:
  - Operands are always captured from i_read_data_x.
  - o_hazard_stall additionally asserts when the bypass condition would hold for i_rs or i_rt with i_valid=1.
  - On the next cycle the bank holds the new value, the write has retired and the stall drops.
  - This case also loads a bubble and increments the counter.

## Test plan
- Reset mid-operation: load valid add (rs=1, rt=2, data 5/7), then assert i_reset -> all outputs 0 after the edge, o_bubble_count=0.
- Plain load: i_valid=1, rs=3, rt=4, data 0x11/0x22, imm 0xFFFFFFF0, reg_write=1 -> next cycle o_valid=1, o_data_1=0x11, o_data_2=0x22, o_imm=0xFFFFFFF0, o_reg_write=1.
- Load-use pair: EX holds lw with rt=8; ID add has rs=8 -> o_hazard_stall=1. Next cycle: o_valid=0, o_reg_write=0, count=1. The following cycle: add loaded, o_hazard_stall=0. Repeat with rt=0 -> no stall.
- WB bypass: wb_write_enable=1, wb reg 5, data 0xDEAD; ID rs=5, i_read_data_1=0x1234 -> with macro, o_data_1=0xDEAD. Without macro: one bubble, then o_data_1 equals the updated bank value. With wb reg 0, no bypass and no stall.
- Priority: i_flush+i_stall -> bubble. i_stall alone for 3 cycles -> all outputs unchanged and count unchanged.
- Counter saturation: force 65537 flushes with i_valid=1 -> o_bubble_count=0xFFFF.
